delay_tap_sched: RTL and testbench

Per-sample scheduler for the shared single-port delay-line RAM. On each sample-period `start` it performs these memory accesses in a fixed order:
- up to `NUM_TAPS` tap reads at configurable offsets behind the write pointer;
- one write of the new sample.

It returns each tap's data with an index and valid strobe, so the effects datapath no longer sequences RAM addresses itself. It sits between the sample-period counter/effects pipeline and the RAM instance.

---
 rtl/fx_pkg.sv | 27 ++
 rtl/tap_addr.sv | 55 +++++
 rtl/delay_tap_sched.sv | 162 ++++++++++++++++
 tb/tb_delay_tap_sched.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared types and defaults for the effects datapath.
// Sample format, scheduler states and width helpers.
package fx_pkg;

    localparam int DEF_ADDR_W   = 13;
    localparam int DEF_DATA_W   = 11;
    localparam int DEF_NUM_TAPS = 4;
    localparam int DEF_DECIM    = 2;

    // Sign-magnitude audio sample: top bit is the sign.
    typedef struct packed {
        logic                    sign;
        logic [DEF_DATA_W-2:0]   mag;
    } sm_sample_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } sched_state_t;

    function automatic int idxW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tap_addr.sv
// Registered RAM address generator for the tap scheduler.
// Keeps slot enable/index aligned with the issued address.
module tap_addr
    import fx_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic              wrIssue,
    input  logic              slotEn,
    input  logic [IDX_W-1:0]  slotIdx,
    input  logic [ADDR_W-1:0] offset,
    input  logic [ADDR_W-1:0] writeAdr,
    output logic [ADDR_W-1:0] memAdr,
    output logic [IDX_W-1:0]  tapIdx,
    output logic              tapValid
);

    logic [ADDR_W-1:0] nextAdr;
    logic              enQ;
    logic [IDX_W-1:0]  idxQ;

    // Subtraction wraps naturally modulo 2^ADDR_W.
    always_comb begin
        nextAdr = memAdr;
        unique case (1'b1)
            wrIssue: nextAdr = writeAdr;
            issue:   nextAdr = writeAdr - offset;
            default: nextAdr = memAdr;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memAdr   <= '0;
            enQ      <= 1'b0;
            idxQ     <= '0;
            tapValid <= 1'b0;
            tapIdx   <= '0;
        end else begin
            memAdr <= nextAdr;
            enQ    <= issue & slotEn;
            if (issue) begin
                idxQ <= slotIdx;
            end
            // RAM data lands one cycle after the address.
            tapValid <= enQ;
            tapIdx   <= idxQ;
        end
    end

endmodule

// File: rtl/delay_tap_sched.sv
// Per-frame scheduler for the shared delay-line RAM:
// NUM_TAPS tap reads behind the write pointer, then one write.
module delay_tap_sched
    import fx_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int DECIM    = DEF_DECIM
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DATA_W-1:0]          sampleIn,
    input  logic [NUM_TAPS-1:0]        tapEn,
    input  logic [NUM_TAPS*ADDR_W-1:0] tapOffset,
    input  logic [DATA_W-1:0]          memRD,
    output logic [ADDR_W-1:0]          memAdr,
    output logic [DATA_W-1:0]          memWD,
    output logic                       memWE,
    output logic [DATA_W-1:0]          tapData,
    output logic [idxW(NUM_TAPS)-1:0]  tapIdx,
    output logic                       tapValid,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam int IDX_W = idxW(NUM_TAPS);
    localparam int FC_W  = idxW(DECIM);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_TAPS - 1);
    localparam logic [FC_W-1:0] LAST_FRAME = FC_W'(DECIM - 1);

    sched_state_t state;
    sched_state_t nextState;

    logic [IDX_W-1:0]           slotK;
    logic [IDX_W-1:0]           slotSel;
    logic                       slotEn;
    logic [ADDR_W-1:0]          slotOff;
    logic                       issue;
    logic                       wrIssue;
    logic                       accept;

    logic [DATA_W-1:0]          sampleQ;
    logic [NUM_TAPS-1:0]        enQ;
    logic [NUM_TAPS*ADDR_W-1:0] offQ;
    logic [ADDR_W-1:0]          writeAdr;
    logic [FC_W-1:0]            frameCnt;

    assign accept = (state == IDLE) && start;

    // Slot 0 is issued from the live inputs so its address
    // is on the bus the cycle after start.
    always_comb begin
        nextState = state;
        issue     = 1'b0;
        wrIssue   = 1'b0;
        slotSel   = '0;
        slotEn    = 1'b0;
        slotOff   = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nextState = READ;
                    issue     = 1'b1;
                    slotEn    = tapEn[0];
                    slotOff   = tapOffset[ADDR_W-1:0];
                end
            end
            READ: begin
                if (slotK == LAST_SLOT) begin
                    nextState = WRITE;
                    wrIssue   = 1'b1;
                end else begin
                    issue   = 1'b1;
                    slotSel = slotK + IDX_W'(1);
                    slotEn  = enQ[slotSel];
                    slotOff = offQ[int'(slotSel)*ADDR_W +: ADDR_W];
                end
            end
            WRITE: nextState = DONE;
            DONE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            slotK   <= '0;
            sampleQ <= '0;
            enQ     <= '0;
            offQ    <= '0;
        end else begin
            state <= nextState;
            if (issue) begin
                slotK <= slotSel;
            end
            if (accept) begin
                sampleQ <= sampleIn;
                enQ     <= tapEn;
                offQ    <= tapOffset;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            writeAdr <= '0;
            frameCnt <= '0;
        end else if (state == DONE) begin
            if (frameCnt == LAST_FRAME) begin
                frameCnt <= '0;
                writeAdr <= writeAdr + ADDR_W'(1);
            end else begin
                frameCnt <= frameCnt + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memWD   <= '0;
            memWE   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            memWE <= wrIssue;
            busy  <= (nextState != IDLE);
            done  <= (nextState == DONE);
            if (wrIssue) begin
                memWD <= sampleQ;
            end
            if (start && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    tap_addr #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) uAddr (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue),
        .wrIssue  (wrIssue),
        .slotEn   (slotEn),
        .slotIdx  (slotSel),
        .offset   (slotOff),
        .writeAdr (writeAdr),
        .memAdr   (memAdr),
        .tapIdx   (tapIdx),
        .tapValid (tapValid)
    );

    // Synchronous RAM output is qualified by the registered strobe.
    assign tapData = tapValid ? memRD : '0;

endmodule

// File: tb/tb_delay_tap_sched.sv
// Self-checking bench for delay_tap_sched with a RAM model
// and a frame-level reference model.
module tb_delay_tap_sched;

    localparam int AW   = 13;
    localparam int DW   = 11;
    localparam int NT   = 4;
    localparam int DEC  = 2;
    localparam int IW   = 2;
    localparam int SIZE = 1 << AW;
    localparam int FL   = NT + 3;
    localparam int OFFW = NT * AW;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [DW-1:0]   sampleIn = '0;
    logic [NT-1:0]   tapEn = '0;
    logic [OFFW-1:0] tapOffset = '0;
    logic [DW-1:0]   memRD;
    logic [AW-1:0]   memAdr;
    logic [DW-1:0]   memWD;
    logic            memWE;
    logic [DW-1:0]   tapData;
    logic [IW-1:0]   tapIdx;
    logic            tapValid;
    logic            busy;
    logic            done;
    logic            overrun;

    delay_tap_sched #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .NUM_TAPS (NT),
        .DECIM    (DEC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sampleIn  (sampleIn),
        .tapEn     (tapEn),
        .tapOffset (tapOffset),
        .memRD     (memRD),
        .memAdr    (memAdr),
        .memWD     (memWD),
        .memWE     (memWE),
        .tapData   (tapData),
        .tapIdx    (tapIdx),
        .tapValid  (tapValid),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram    [SIZE];
    logic [DW-1:0] shadow [SIZE];
    int weCount = 0;

    always @(posedge clk) begin
        if (memWE) begin
            ram[memAdr] <= memWD;
            weCount++;
        end
        memRD <= ram[memAdr];
    end

    int nRun = 0;
    int nFail = 0;

    int mWA;
    int mFc;
    bit mOvr;

    logic [AW-1:0] cAdr   [0:FL];
    logic [DW-1:0] cWD    [0:FL];
    logic [DW-1:0] cData  [0:FL];
    logic [IW-1:0] cIdx   [0:FL];
    logic          cWE    [0:FL];
    logic          cValid [0:FL];
    logic          cBusy  [0:FL];
    logic          cDone  [0:FL];
    logic          cOvr   [0:FL];

    int            eAdr   [0:FL];
    int            eIdx   [0:FL];
    int            eData  [0:FL];
    bit            eWE    [0:FL];
    bit            eValid [0:FL];
    bit            eBusy  [0:FL];
    bit            eDone  [0:FL];
    bit            eOvr   [0:FL];
    logic [DW-1:0] eWD;

    function automatic logic [OFFW-1:0] randOff();
        logic [OFFW-1:0] r;
        for (int k = 0; k < NT; k++) begin
            r[k*AW +: AW] = AW'($urandom);
        end
        return r;
    endfunction

    // Frame-level model: what each cycle of a frame should show.
    task automatic model_frame(input logic [DW-1:0] s,
                               input logic [NT-1:0] en,
                               input logic [OFFW-1:0] off,
                               input bit disturb);
        int a;
        for (int c = 0; c <= FL; c++) begin
            eAdr[c]   = -1;
            eIdx[c]   = 0;
            eData[c]  = 0;
            eWE[c]    = 1'b0;
            eValid[c] = 1'b0;
            eBusy[c]  = (c >= 1) && (c <= NT + 2);
            eDone[c]  = (c == NT + 2);
            eOvr[c]   = mOvr || (disturb && c >= 4);
        end
        for (int k = 0; k < NT; k++) begin
            a = (mWA - int'(off[k*AW +: AW]) + SIZE) % SIZE;
            eAdr[1+k]   = a;
            eValid[2+k] = en[k];
            eIdx[2+k]   = k;
            eData[2+k]  = int'(shadow[a]);
        end
        eAdr[NT+1] = mWA;
        eWE[NT+1]  = 1'b1;
        eWD        = s;
        shadow[mWA] = s;
        mFc++;
        if (mFc == DEC) begin
            mFc = 0;
            mWA = (mWA + 1) % SIZE;
        end
        if (disturb) begin
            mOvr = 1'b1;
        end
    endtask

    task automatic capture(input int c);
        cAdr[c]   = memAdr;
        cWD[c]    = memWD;
        cData[c]  = tapData;
        cIdx[c]   = tapIdx;
        cWE[c]    = memWE;
        cValid[c] = tapValid;
        cBusy[c]  = busy;
        cDone[c]  = done;
        cOvr[c]   = overrun;
    endtask

    // Called at a negedge; returns at the negedge where the
    // next start may be presented.
    task automatic run_frame(input logic [DW-1:0] s,
                             input logic [NT-1:0] en,
                             input logic [OFFW-1:0] off,
                             input bit disturb);
        model_frame(s, en, off, disturb);
        capture(0);
        start     = 1'b1;
        sampleIn  = s;
        tapEn     = en;
        tapOffset = off;
        for (int c = 1; c <= FL; c++) begin
            @(negedge clk);
            capture(c);
            if (c == 1) start = 1'b0;
            if (disturb && c == 2) begin
                sampleIn  = ~s;
                tapEn     = NT'($urandom);
                tapOffset = randOff();
            end
            if (disturb && c == 3) start = 1'b1;
            if (c == 4) start = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mWA  = 0;
        mFc  = 0;
        mOvr = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW+2*DW+IW+6-1:0] outs;
        for (int i = 0; i < SIZE; i++) begin
            ram[i]    = DW'($urandom);
            shadow[i] = ram[i];
        end
        repeat (2) @(negedge clk);
        outs = {memAdr, memWD, memWE, tapData, tapIdx,
                tapValid, busy, done, overrun};
        nRun++;
        if (outs !== '0) begin
            nFail++;
            $display("FAIL reset_outs got %h want 0", outs);
        end
        reset = 1'b1;
        mWA  = 0;
        mFc  = 0;
        mOvr = 1'b0;
        @(negedge clk);
        nRun++;
        if ({busy, done, memWE, tapValid} !== 4'b0) begin
            nFail++;
            $display("FAIL reset_idle got %b want 0000",
                     {busy, done, memWE, tapValid});
        end
    endtask

    task automatic test_basic();
        int wantAdr [0:NT];
        wantAdr = '{'h1E00, 'h1D00, 'h1C00, 'h1FFF, 'h0000};
        do_reset();
        run_frame(DW'($urandom), 4'b1111,
                  {13'h001, 13'h400, 13'h300, 13'h200}, 1'b0);
        for (int c = 1; c <= NT + 1; c++) begin
            nRun++;
            if (cAdr[c] !== AW'(wantAdr[c-1])) begin
                nFail++;
                $display("FAIL basic_adr c=%0d got %h want %h",
                         c, cAdr[c], wantAdr[c-1]);
            end
        end
        for (int c = 0; c <= FL; c++) begin
            nRun++;
            if (cBusy[c] !== eBusy[c] || cDone[c] !== eDone[c] ||
                cWE[c] !== eWE[c] || cValid[c] !== eValid[c]) begin
                nFail++;
                $display("FAIL basic_ctrl c=%0d got %b%b%b%b want %b%b%b%b",
                         c, cBusy[c], cDone[c], cWE[c], cValid[c],
                         eBusy[c], eDone[c], eWE[c], eValid[c]);
            end
            if (eValid[c]) begin
                nRun++;
                if (cIdx[c] !== IW'(eIdx[c]) ||
                    cData[c] !== DW'(eData[c])) begin
                    nFail++;
                    $display("FAIL basic_tap c=%0d got %0d/%h want %0d/%h",
                             c, cIdx[c], cData[c], eIdx[c], eData[c]);
                end
            end
        end
        nRun++;
        if (cWD[NT+1] !== eWD) begin
            nFail++;
            $display("FAIL basic_wd got %h want %h", cWD[NT+1], eWD);
        end
    endtask

    task automatic test_decim();
        int want [3];
        want = '{0, 0, 1};
        do_reset();
        for (int f = 0; f < 3; f++) begin
            run_frame(DW'($urandom), NT'($urandom), randOff(), 1'b0);
            nRun++;
            if (cAdr[NT+1] !== AW'(want[f]) || cWE[NT+1] !== 1'b1) begin
                nFail++;
                $display("FAIL decim_wadr f=%0d got %h/%b want %h/1",
                         f, cAdr[NT+1], cWE[NT+1], want[f]);
            end
        end
    endtask

    task automatic test_wrap();
        int want [3];
        want = '{'h1FFF, 'h1FFF, 'h0000};
        do_reset();
        force dut.writeAdr = 13'h1FFF;
        @(posedge clk);
        #1;
        release dut.writeAdr;
        @(negedge clk);
        mWA = 'h1FFF;
        for (int f = 0; f < 3; f++) begin
            run_frame(DW'($urandom), 4'b1111, randOff(), 1'b0);
            nRun++;
            if (cAdr[NT+1] !== AW'(want[f])) begin
                nFail++;
                $display("FAIL wrap_wadr f=%0d got %h want %h",
                         f, cAdr[NT+1], want[f]);
            end
        end
    endtask

    task automatic test_partial_en();
        bit wantV;
        run_frame(DW'($urandom), 4'b0101, randOff(), 1'b0);
        for (int c = 2; c <= NT + 1; c++) begin
            wantV = (c == 2) || (c == 4);
            nRun++;
            if (cValid[c] !== wantV) begin
                nFail++;
                $display("FAIL part_valid c=%0d got %b want %b",
                         c, cValid[c], wantV);
            end
            if (wantV) begin
                nRun++;
                if (cIdx[c] !== IW'(c - 2) ||
                    cData[c] !== DW'(eData[c])) begin
                    nFail++;
                    $display("FAIL part_tap c=%0d got %0d/%h want %0d/%h",
                             c, cIdx[c], cData[c], c - 2, eData[c]);
                end
            end
        end
        nRun++;
        if (cWE[NT+1] !== 1'b1 || cAdr[NT+1] !== AW'(eAdr[NT+1])) begin
            nFail++;
            $display("FAIL part_write got %b@%h want 1@%h",
                     cWE[NT+1], cAdr[NT+1], eAdr[NT+1]);
        end
    endtask

    task automatic test_midframe();
        logic [DW-1:0] s;
        s = DW'($urandom);
        nRun++;
        if (overrun !== 1'b0) begin
            nFail++;
            $display("FAIL ovr_pre got %b want 0", overrun);
        end
        run_frame(s, 4'b1111, randOff(), 1'b1);
        nRun++;
        if (cWD[NT+1] !== s || cWE[NT+1] !== 1'b1) begin
            nFail++;
            $display("FAIL hold_wd got %h/%b want %h/1",
                     cWD[NT+1], cWE[NT+1], s);
        end
        for (int c = 0; c <= FL; c++) begin
            nRun++;
            if (cOvr[c] !== eOvr[c] || cDone[c] !== eDone[c] ||
                cBusy[c] !== eBusy[c]) begin
                nFail++;
                $display("FAIL ovr_timing c=%0d got %b%b%b want %b%b%b",
                         c, cOvr[c], cDone[c], cBusy[c],
                         eOvr[c], eDone[c], eBusy[c]);
            end
            if (eValid[c]) begin
                nRun++;
                if (cData[c] !== DW'(eData[c]) || cValid[c] !== 1'b1) begin
                    nFail++;
                    $display("FAIL hold_tap c=%0d got %h want %h",
                             c, cData[c], eData[c]);
                end
            end
        end
        run_frame(DW'($urandom), NT'($urandom), randOff(), 1'b0);
        nRun++;
        if (cOvr[FL] !== 1'b1) begin
            nFail++;
            $display("FAIL ovr_sticky got %b want 1", cOvr[FL]);
        end
        do_reset();
        nRun++;
        if (overrun !== 1'b0) begin
            nFail++;
            $display("FAIL ovr_clear got %b want 0", overrun);
        end
    endtask

    task automatic test_reset_midframe();
        int weBefore;
        logic [AW+2*DW+IW+6-1:0] outs;
        run_frame(DW'($urandom), 4'b1111, randOff(), 1'b0);
        run_frame(DW'($urandom), 4'b1111, randOff(), 1'b0);
        start     = 1'b1;
        sampleIn  = DW'($urandom);
        tapEn     = 4'b1111;
        tapOffset = randOff();
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        weBefore = weCount;
        reset = 1'b0;
        #1;
        outs = {memAdr, memWD, memWE, tapData, tapIdx,
                tapValid, busy, done, overrun};
        nRun++;
        if (outs !== '0) begin
            nFail++;
            $display("FAIL rstmid_outs got %h want 0", outs);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        mWA  = 0;
        mFc  = 0;
        mOvr = 1'b0;
        @(negedge clk);
        nRun++;
        if (weCount !== weBefore) begin
            nFail++;
            $display("FAIL rstmid_nowrite got %0d want %0d",
                     weCount, weBefore);
        end
        run_frame(DW'($urandom), 4'b1111, randOff(), 1'b0);
        nRun++;
        if (cAdr[NT+1] !== '0 || cWE[NT+1] !== 1'b1 ||
            cDone[NT+2] !== 1'b1) begin
            nFail++;
            $display("FAIL rstmid_first got %h/%b/%b want 0/1/1",
                     cAdr[NT+1], cWE[NT+1], cDone[NT+2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [OFFW-1:0] off;
        for (int f = 0; f < 24; f++) begin
            off = randOff();
            for (int k = 0; k < NT; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    off[k*AW +: AW] = AW'($urandom_range(0, 2));
                end
            end
            run_frame(DW'($urandom), NT'($urandom), off,
                      ($urandom_range(0, 5) == 0));
            for (int c = 0; c <= FL; c++) begin
                nRun++;
                if (cBusy[c] !== eBusy[c] || cDone[c] !== eDone[c] ||
                    cWE[c] !== eWE[c] || cValid[c] !== eValid[c] ||
                    cOvr[c] !== eOvr[c]) begin
                    nFail++;
                    $display("FAIL b2b_ctrl f=%0d c=%0d got %b%b%b%b%b want %b%b%b%b%b",
                             f, c, cBusy[c], cDone[c], cWE[c],
                             cValid[c], cOvr[c], eBusy[c], eDone[c],
                             eWE[c], eValid[c], eOvr[c]);
                end
                if (eAdr[c] >= 0) begin
                    nRun++;
                    if (cAdr[c] !== AW'(eAdr[c])) begin
                        nFail++;
                        $display("FAIL b2b_adr f=%0d c=%0d got %h want %h",
                                 f, c, cAdr[c], eAdr[c]);
                    end
                end
                if (eValid[c]) begin
                    nRun++;
                    if (cIdx[c] !== IW'(eIdx[c]) ||
                        cData[c] !== DW'(eData[c])) begin
                        nFail++;
                        $display("FAIL b2b_tap f=%0d c=%0d got %0d/%h want %0d/%h",
                                 f, c, cIdx[c], cData[c],
                                 eIdx[c], eData[c]);
                    end
                end
            end
            nRun++;
            if (cWD[NT+1] !== eWD) begin
                nFail++;
                $display("FAIL b2b_wd f=%0d got %h want %h",
                         f, cWD[NT+1], eWD);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d checks", nRun);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_decim();
        test_wrap();
        test_partial_en();
        test_midframe();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
